// File: rtl/dht11_frame_rx.sv
// DHT11 single-wire frame receiver: issues the host start pulse, times the sensor ACK and 40 data
// bits, verifies the checksum and publishes humidity/temperature as x10 fixed-point words.
module dht11_frame_rx #(
    parameter int CLK_FREQ_MHZ  = 50,
    parameter int START_LOW_US  = 20000,
    parameter int PERIOD_US     = 2000000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        dht11_in,
    output logic        dht11_oe,
    output logic [19:0] hum_x10,
    output logic [19:0] temp_x10,
    output logic        temp_neg,
    output logic        data_valid,
    output logic        crc_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int DIV_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_FREQ_MHZ - 1);
    localparam int TMR_W = 32;
    localparam logic [TMR_W-1:0] PERIOD_LAST  = TMR_W'(PERIOD_US - 1);
    localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_LOW_US - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_US - 1);
    localparam logic [TMR_W-1:0] THRESH_LAST  = TMR_W'(BIT_THRESH_US - 1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX      = {TMR_W{1'b1}};
    localparam logic [5:0]       LAST_BIT     = 6'd39;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_REL   = 3'd2;
    localparam logic [2:0] ST_ACK_L = 3'd3;
    localparam logic [2:0] ST_ACK_H = 3'd4;
    localparam logic [2:0] ST_BIT_L = 3'd5;
    localparam logic [2:0] ST_BIT_H = 3'd6;
    localparam logic [2:0] ST_CHECK = 3'd7;

    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (sum == frame[7:0]);
    endfunction

    function automatic logic [19:0] times10(input logic [7:0] x);
        logic [19:0] xw;
        xw = {12'd0, x};
        return (xw << 3) + (xw << 1);
    endfunction

    logic [1:0]       sync_r;
    logic             line_d_r;
    logic             line_s;
    logic             rise_s;
    logic             fall_s;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [TMR_W-1:0] timer_r;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [5:0]       bit_cnt_r;
    logic [39:0]      shift_r;
    logic             shift_en_s;
    logic             bit_val_s;
    logic             clr_cnt_s;
    logic             abort_s;
    logic             timeout_s;
    logic             check_s;
    logic             crc_ok_s;
    logic [19:0]      hum_nxt_s;
    logic [19:0]      temp_nxt_s;
    logic             oe_r;
    logic             busy_r;
    logic [19:0]      hum_x10_r;
    logic [19:0]      temp_x10_r;
    logic             temp_neg_r;
    logic             data_valid_r;
    logic             crc_err_r;
    logic             timeout_err_r;

    // Two-flop synchroniser plus a delayed copy for edge detection; idle line is high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_r   <= 2'b11;
            line_d_r <= 1'b1;
        end else begin
            sync_r   <= {sync_r[0], dht11_in};
            line_d_r <= sync_r[1];
        end
    end

    assign line_s = sync_r[1];
    assign rise_s = line_s & ~line_d_r;
    assign fall_s = ~line_s & line_d_r;

    // 1 us tick divider.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_r <= DIV_MAX;
        end else if (div_r == {DIV_W{1'b0}}) begin
            div_r <= DIV_MAX;
        end else begin
            div_r <= div_r - DIV_W'(1);
        end
    end

    assign tick_s    = (div_r == {DIV_W{1'b0}});
    assign timeout_s = tick_s && (timer_r >= TIMEOUT_LAST);

    // Phase timer: counts ticks within a state, cleared on every state change.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (tick_s && (timer_r != TMR_MAX)) begin
            timer_r <= timer_r + TMR_ONE;
        end
    end

    // Next-state logic; a line edge takes priority over a coincident timeout.
    always_comb begin
        state_nxt_s = state_r;
        shift_en_s  = 1'b0;
        bit_val_s   = 1'b0;
        clr_cnt_s   = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && (timer_r >= PERIOD_LAST)) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (timer_r >= START_LAST)) begin
                    state_nxt_s = ST_REL;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_REL: begin
                if (!line_s) begin
                    state_nxt_s = ST_ACK_L;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_REL;
                end
            end
            ST_ACK_L: begin
                if (rise_s) begin
                    state_nxt_s = ST_ACK_H;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_ACK_L;
                end
            end
            ST_ACK_H: begin
                if (fall_s) begin
                    state_nxt_s = ST_BIT_L;
                    clr_cnt_s   = 1'b1;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_ACK_H;
                end
            end
            ST_BIT_L: begin
                if (rise_s) begin
                    state_nxt_s = ST_BIT_H;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_BIT_L;
                end
            end
            ST_BIT_H: begin
                // The timer restarted one cycle after the rise was seen, so it lags the width by one.
                if (fall_s) begin
                    shift_en_s = 1'b1;
                    bit_val_s  = (timer_r >= THRESH_LAST);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_BIT_L;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_BIT_H;
                end
            end
            ST_CHECK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered pad enable and busy flag aligned to the state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            oe_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            oe_r    <= (state_nxt_s == ST_START);
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Bit counter and MSB-first shift register; an aborted frame is discarded.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_cnt_r <= 6'd0;
            shift_r   <= 40'd0;
        end else if (clr_cnt_s || abort_s) begin
            bit_cnt_r <= 6'd0;
            shift_r   <= 40'd0;
        end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
            shift_r   <= {shift_r[38:0], bit_val_s};
        end
    end

    assign check_s    = (state_r == ST_CHECK);
    assign crc_ok_s   = checksum_ok(shift_r);
    assign hum_nxt_s  = times10(shift_r[39:32]) + {12'd0, shift_r[31:24]};
    assign temp_nxt_s = times10(shift_r[23:16]) + {13'd0, shift_r[14:8]};

    // Result registers hold the last good frame; status pulses last exactly one cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hum_x10_r     <= 20'd0;
            temp_x10_r    <= 20'd0;
            temp_neg_r    <= 1'b0;
            data_valid_r  <= 1'b0;
            crc_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            data_valid_r  <= check_s & crc_ok_s;
            crc_err_r     <= check_s & ~crc_ok_s;
            timeout_err_r <= abort_s;
            if (check_s && crc_ok_s) begin
                hum_x10_r  <= hum_nxt_s;
                temp_x10_r <= temp_nxt_s;
                temp_neg_r <= shift_r[15];
            end
        end
    end

    assign dht11_oe    = oe_r;
    assign busy        = busy_r;
    assign hum_x10     = hum_x10_r;
    assign temp_x10    = temp_x10_r;
    assign temp_neg    = temp_neg_r;
    assign data_valid  = data_valid_r;
    assign crc_err     = crc_err_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_dht11_frame_rx.sv
// Directed bench for dht11_frame_rx: a behavioural DHT11 sensor drives the line, one clock = 1 us.
module tb_dht11_frame_rx;

    logic        sys_clk;
    logic        sys_rst;
    logic        sensor_line;
    logic        dht11_in;
    logic        dht11_oe;
    logic [19:0] hum_x10;
    logic [19:0] temp_x10;
    logic        temp_neg;
    logic        data_valid;
    logic        crc_err;
    logic        timeout_err;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;
    int dv_cnt   = 0;
    int crc_cnt  = 0;
    int to_cnt   = 0;
    int multi_cnt = 0;

    dht11_frame_rx #(
        .CLK_FREQ_MHZ (1),
        .START_LOW_US (20),
        .PERIOD_US    (100),
        .TIMEOUT_US   (200),
        .BIT_THRESH_US(50)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .dht11_in   (dht11_in),
        .dht11_oe   (dht11_oe),
        .hum_x10    (hum_x10),
        .temp_x10   (temp_x10),
        .temp_neg   (temp_neg),
        .data_valid (data_valid),
        .crc_err    (crc_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    // Open-drain line: host pull-down wins over the sensor.
    assign dht11_in = dht11_oe ? 1'b0 : sensor_line;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Pulse counters sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (data_valid)  dv_cnt  <= dv_cnt + 1;
        if (crc_err)     crc_cnt <= crc_cnt + 1;
        if (timeout_err) to_cnt  <= to_cnt + 1;
        if ((32'(data_valid) + 32'(crc_err) + 32'(timeout_err)) > 32'd1) multi_cnt <= multi_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_oe(input logic lvl, input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (dht11_oe === lvl) ok = 1'b1;
        end
    endtask

    task automatic wait_timeout(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (timeout_err === 1'b1) seen = 1'b1;
        end
    endtask

    // Sensor model: ACK 80 low / 80 high, then per bit 50 low + h0/h1 high, then 50 low and release.
    task automatic sensor_frame(input logic [39:0] frame, input int nbits, input int h0, input int h1,
                                output bit ok);
        bit got;
        int n;
        ok = 1'b1;
        wait_oe(1'b1, 2000, got, n);
        if (!got) ok = 1'b0;
        sensor_line = 1'b0;
        wait_oe(1'b0, 2000, got, n);
        if (!got) ok = 1'b0;
        if (ok) begin
            repeat (80) @(negedge sys_clk);
            sensor_line = 1'b1;
            repeat (80) @(negedge sys_clk);
            for (int i = 0; i < nbits; i++) begin
                sensor_line = 1'b0;
                repeat (50) @(negedge sys_clk);
                sensor_line = 1'b1;
                repeat (frame[39-i] ? h1 : h0) @(negedge sys_clk);
            end
            sensor_line = 1'b0;
            repeat (50) @(negedge sys_clk);
        end
        sensor_line = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        sys_rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_checks++; if (dht11_oe !== 1'b0) begin n_fails++; $display("FAIL reset_oe: got %b expected 0", dht11_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (hum_x10 !== 20'd0) begin n_fails++; $display("FAIL reset_hum: got %0d expected 0", hum_x10); end
        n_checks++; if (temp_x10 !== 20'd0) begin n_fails++; $display("FAIL reset_temp: got %0d expected 0", temp_x10); end
        n_checks++; if ({temp_neg, data_valid, crc_err, timeout_err} !== 4'b0000) begin
            n_fails++; $display("FAIL reset_flags: got %b expected 0000", {temp_neg, data_valid, crc_err, timeout_err});
        end
        sys_rst = 1'b0;
        wait_oe(1'b1, 500, ok, n);
        n_checks++; if (!ok || n != 100) begin n_fails++; $display("FAIL first_start: got %0d cycles (seen=%0b) expected 100", n, ok); end
    endtask

    task automatic test_good_frame();
        bit ok;
        int dv0, crc0, to0;
        dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
        sensor_frame(40'h37_00_18_03_52, 40, 26, 70, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL good_handshake: got no START/release expected both"); end
        n_checks++; if (hum_x10 !== 20'd550) begin n_fails++; $display("FAIL good_hum: got %0d expected 550", hum_x10); end
        n_checks++; if (temp_x10 !== 20'd243) begin n_fails++; $display("FAIL good_temp: got %0d expected 243", temp_x10); end
        n_checks++; if (temp_neg !== 1'b0) begin n_fails++; $display("FAIL good_neg: got %b expected 0", temp_neg); end
        n_checks++; if (dv_cnt - dv0 != 1) begin n_fails++; $display("FAIL good_valid_pulses: got %0d expected 1", dv_cnt - dv0); end
        n_checks++; if ((crc_cnt - crc0) + (to_cnt - to0) != 0) begin
            n_fails++; $display("FAIL good_err_pulses: got %0d expected 0", (crc_cnt - crc0) + (to_cnt - to0));
        end
    endtask

    task automatic test_crc_error();
        bit ok;
        int dv0, crc0;
        dv0 = dv_cnt; crc0 = crc_cnt;
        sensor_frame(40'h37_00_18_03_53, 40, 26, 70, ok);
        n_checks++; if (crc_cnt - crc0 != 1) begin n_fails++; $display("FAIL crc_pulses: got %0d expected 1", crc_cnt - crc0); end
        n_checks++; if (dv_cnt - dv0 != 0) begin n_fails++; $display("FAIL crc_valid_pulses: got %0d expected 0", dv_cnt - dv0); end
        n_checks++; if (hum_x10 !== 20'd550) begin n_fails++; $display("FAIL crc_hum_hold: got %0d expected 550", hum_x10); end
        n_checks++; if (temp_x10 !== 20'd243) begin n_fails++; $display("FAIL crc_temp_hold: got %0d expected 243", temp_x10); end
    endtask

    task automatic test_bit_threshold();
        bit ok;
        int dv0;
        dv0 = dv_cnt;
        // 0x41,0x05,0x9A,0x87 sum 0x67: hum 65*10+5, temp 154*10+7, sign bit set
        sensor_frame(40'h41_05_9A_87_67, 40, 49, 50, ok);
        n_checks++; if (dv_cnt - dv0 != 1) begin n_fails++; $display("FAIL thresh_valid_pulses: got %0d expected 1", dv_cnt - dv0); end
        n_checks++; if (hum_x10 !== 20'd655) begin n_fails++; $display("FAIL thresh_hum: got %0d expected 655", hum_x10); end
        n_checks++; if (temp_x10 !== 20'd1547) begin n_fails++; $display("FAIL thresh_temp: got %0d expected 1547", temp_x10); end
        n_checks++; if (temp_neg !== 1'b1) begin n_fails++; $display("FAIL thresh_neg: got %b expected 1", temp_neg); end
    endtask

    task automatic test_no_response();
        bit ok, seen;
        int n, to0, dv0, crc0;
        to0 = to_cnt; dv0 = dv_cnt; crc0 = crc_cnt;
        sensor_line = 1'b1;
        wait_oe(1'b1, 2000, ok, n);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL noresp_start: got no START in %0d cycles expected one", n); end
        wait_oe(1'b0, 2000, ok, n);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL noresp_release: got oe still 1 expected 0"); end
        // 200 us timeout plus the synchroniser lag before the pulled-up line is seen
        wait_timeout(400, seen, n);
        n_checks++; if (!seen || n < 200 || n > 206) begin
            n_fails++; $display("FAIL noresp_timeout: got %0d cycles (seen=%0b) expected 200..206", n, seen);
        end
        wait_oe(1'b1, 500, ok, n);
        n_checks++; if (!ok || n != 100) begin n_fails++; $display("FAIL noresp_restart: got %0d cycles expected 100", n); end
        n_checks++; if (to_cnt - to0 != 1) begin n_fails++; $display("FAIL noresp_to_pulses: got %0d expected 1", to_cnt - to0); end
        n_checks++; if ((dv_cnt - dv0) + (crc_cnt - crc0) != 0) begin
            n_fails++; $display("FAIL noresp_other_pulses: got %0d expected 0", (dv_cnt - dv0) + (crc_cnt - crc0));
        end
    endtask

    task automatic test_truncated_frame();
        bit ok, seen;
        int n, to0, dv0;
        to0 = to_cnt; dv0 = dv_cnt;
        sensor_frame(40'h37_00_18_03_52, 23, 26, 70, ok);
        wait_timeout(400, seen, n);
        n_checks++; if (!seen) begin n_fails++; $display("FAIL trunc_timeout: got none in %0d cycles expected pulse", n); end
        repeat (2) @(negedge sys_clk);
        n_checks++; if (to_cnt - to0 != 1) begin n_fails++; $display("FAIL trunc_to_pulses: got %0d expected 1", to_cnt - to0); end
        n_checks++; if (dv_cnt - dv0 != 0) begin n_fails++; $display("FAIL trunc_valid_pulses: got %0d expected 0", dv_cnt - dv0); end
        n_checks++; if (hum_x10 !== 20'd655 || temp_x10 !== 20'd1547) begin
            n_fails++; $display("FAIL trunc_hold: got %0d/%0d expected 655/1547", hum_x10, temp_x10);
        end
        dv0 = dv_cnt;
        sensor_frame(40'h37_00_18_03_52, 40, 26, 70, ok);
        n_checks++; if (dv_cnt - dv0 != 1) begin n_fails++; $display("FAIL trunc_recover_valid: got %0d expected 1", dv_cnt - dv0); end
        n_checks++; if (hum_x10 !== 20'd550 || temp_x10 !== 20'd243 || temp_neg !== 1'b0) begin
            n_fails++; $display("FAIL trunc_recover_data: got %0d/%0d/%b expected 550/243/0", hum_x10, temp_x10, temp_neg);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        wait_oe(1'b1, 2000, ok, n);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL midrst_start: got no START expected one"); end
        repeat (5) @(negedge sys_clk);
        n_checks++; if (busy !== 1'b1 || dht11_oe !== 1'b1) begin
            n_fails++; $display("FAIL midrst_busy_before: got busy=%b oe=%b expected 1/1", busy, dht11_oe);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (dht11_oe !== 1'b0) begin n_fails++; $display("FAIL midrst_oe: got %b expected 0", dht11_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (hum_x10 !== 20'd0 || temp_x10 !== 20'd0 || temp_neg !== 1'b0) begin
            n_fails++; $display("FAIL midrst_outputs: got %0d/%0d/%b expected 0/0/0", hum_x10, temp_x10, temp_neg);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_oe(1'b1, 500, ok, n);
        n_checks++; if (!ok || n != 100) begin n_fails++; $display("FAIL midrst_restart: got %0d cycles expected 100", n); end
        n_checks++; if (multi_cnt != 0) begin n_fails++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", multi_cnt); end
    endtask

    initial begin
        sys_rst     = 1'b1;
        sensor_line = 1'b1;
        test_reset();
        test_good_frame();
        test_crc_error();
        test_bit_threshold();
        test_no_response();
        test_truncated_frame();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
